// File: rtl/pool_window_gather.sv
// Regroups a raster pixel stream into 2x2 non-overlapping windows, emitted as
// four consecutive elements: top[x], top[x+1], bot[x], bot[x+1].
module pool_window_gather #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  window_last,
  output logic                  frame_done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT / 2) : 1;
  localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_PAIR_LAST = COL_W'(IMG_WIDTH - 2);
  localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_HEIGHT / 2 - 1);

  typedef enum logic [1:0] {
    ST_TOP  = 2'd0,
    ST_BOT0 = 2'd1,
    ST_BOT1 = 2'd2,
    ST_EMIT = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [ROW_W-1:0]      row_pair_q, row_pair_d;
  logic [1:0]            e_q, e_d;
  logic [DATA_WIDTH-1:0] b0_q, b0_d;
  logic [DATA_WIDTH-1:0] b1_q, b1_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  window_last_q, window_last_d;
  logic                  frame_done_q, frame_done_d;
  logic [DATA_WIDTH-1:0] line_buf_q [IMG_WIDTH];
  logic                  lb_we;
  logic                  in_fire;
  logic                  out_fire;

  assign in_ready    = enable && (state_q != ST_EMIT);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid_q && out_ready;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign window_last = window_last_q;
  assign frame_done  = frame_done_q;

  // Next-state, counter and output-register computation
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_pair_d    = row_pair_q;
    e_d           = e_q;
    b0_d          = b0_q;
    b1_d          = b1_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    window_last_d = window_last_q;
    frame_done_d  = 1'b0;
    lb_we         = 1'b0;
    case (state_q)
      ST_TOP: begin
        if (in_fire) begin
          lb_we = 1'b1;
          if (col_q == COL_LAST) begin
            col_d   = {COL_W{1'b0}};
            state_d = ST_BOT0;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end else begin
          lb_we = 1'b0;
        end
      end
      ST_BOT0: begin
        if (in_fire) begin
          b0_d    = in_data;
          state_d = ST_BOT1;
        end else begin
          b0_d = b0_q;
        end
      end
      ST_BOT1: begin
        if (in_fire) begin
          b1_d          = in_data;
          state_d       = ST_EMIT;
          out_valid_d   = 1'b1;
          out_data_d    = line_buf_q[col_q];
          e_d           = 2'd0;
          window_last_d = 1'b0;
        end else begin
          b1_d = b1_q;
        end
      end
      ST_EMIT: begin
        if (out_fire) begin
          case (e_q)
            2'd0: begin
              out_data_d = line_buf_q[col_q + COL_W'(1)];
              e_d        = 2'd1;
            end
            2'd1: begin
              out_data_d = b0_q;
              e_d        = 2'd2;
            end
            2'd2: begin
              out_data_d    = b1_q;
              e_d           = 2'd3;
              window_last_d = 1'b1;
            end
            2'd3: begin
              out_valid_d   = 1'b0;
              window_last_d = 1'b0;
              e_d           = 2'd0;
              if (col_q != COL_PAIR_LAST) begin
                col_d   = col_q + COL_W'(2);
                state_d = ST_BOT0;
              end else if (row_pair_q != ROW_LAST) begin
                col_d      = {COL_W{1'b0}};
                row_pair_d = row_pair_q + ROW_W'(1);
                state_d    = ST_TOP;
              end else begin
                col_d        = {COL_W{1'b0}};
                row_pair_d   = {ROW_W{1'b0}};
                frame_done_d = 1'b1;
                state_d      = ST_TOP;
              end
            end
            default: begin
              e_d = 2'd0;
            end
          endcase
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      default: begin
        state_d = ST_TOP;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_TOP;
      col_q         <= {COL_W{1'b0}};
      row_pair_q    <= {ROW_W{1'b0}};
      e_q           <= 2'd0;
      b0_q          <= {DATA_WIDTH{1'b0}};
      b1_q          <= {DATA_WIDTH{1'b0}};
      out_data_q    <= {DATA_WIDTH{1'b0}};
      out_valid_q   <= 1'b0;
      window_last_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_pair_q    <= row_pair_d;
      e_q           <= e_d;
      b0_q          <= b0_d;
      b1_q          <= b1_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      window_last_q <= window_last_d;
      frame_done_q  <= frame_done_d;
    end
  end

  // Top-row line buffer; every entry is rewritten before it is read
  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf_q[col_q] <= in_data;
    end
  end

endmodule

// File: doc/pool_window_gather.md
POOL_WINDOW_GATHER -- requirements
Module: pool_window_gather

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 64: pixels per row; even, at least 2.
REQ-002 SHALL have parameter IMG_HEIGHT, default 64: rows per frame; even, at least 2.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: pixel width in bits.
REQ-004 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: when low, in_ready is low; output handshakes still complete.
REQ-007 SHALL have port in_data, input, DATA_WIDTH: raster-order pixel of one channel.
REQ-008 SHALL have port in_valid, input, 1: in_data is valid.
REQ-009 SHALL have port in_ready, output, 1: combinational; a pixel transfers when in_valid and in_ready are both high.
REQ-010 SHALL have port out_data, output, DATA_WIDTH: registered window element.
REQ-011 SHALL have port out_valid, output, 1: registered; out_data is valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts; an element transfers when out_valid and out_ready are both high; tie high for a sink that cannot stall.
REQ-013 SHALL have port window_last, output, 1: high with the 4th element of each 2x2 window.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse after the final window of a frame transfers.

Function
REQ-015 SHALL convert the raster stream into 2x2 non-overlapping windows, each emitted as 4 consecutive elements in this order: top[x], top[x+1], bot[x], bot[x+1], for x even.
REQ-016 SHALL hold one full row in a line buffer of IMG_WIDTH x DATA_WIDTH entries, plus two bottom registers b0 and b1.
REQ-017 SHALL implement states TOP, BOT0, BOT1 and EMIT; reset enters TOP with col=0, row_pair=0 and emit index e=0.
REQ-018 in TOP, in_ready SHALL equal enable; each transfer writes line_buf[col] and increments col; the transfer at col=IMG_WIDTH-1 sets col=0 and moves to BOT0.
REQ-019 in BOT0, in_ready SHALL equal enable; a transfer stores b0 and moves to BOT1.
REQ-020 in BOT1, in_ready SHALL equal enable; a transfer stores b1 and moves to EMIT, with out_valid=1 and out_data=line_buf[col] on the next cycle.
REQ-021 in EMIT, in_ready SHALL be 0.
REQ-022 in EMIT, out_data and out_valid SHALL hold stable while out_valid is high and out_ready is low.
REQ-023 in EMIT, each element transfer SHALL advance e and present line_buf[col+1], then b0, then b1 on the following cycle, so the block sustains one element per cycle while out_ready is held high.
REQ-024 window_last SHALL be 1 exactly while e=3 and out_valid=1.
REQ-025 on the transfer at e=3, if col < IMG_WIDTH-2: out_valid<=0, e<=0, col<=col+2, next state BOT0.
REQ-026 on the transfer at e=3, if col = IMG_WIDTH-2 and row_pair < IMG_HEIGHT/2-1: out_valid<=0, e<=0, col<=0, row_pair<=row_pair+1, next state TOP.
REQ-027 on the transfer at e=3, if col = IMG_WIDTH-2 and row_pair = IMG_HEIGHT/2-1: out_valid<=0, e<=0, col<=0, row_pair<=0, frame_done<=1 for one cycle, next state TOP; the next frame is accepted with no gap.
REQ-028 SHALL accept at most one input pixel per cycle; in_valid low in any input state stalls that state with no change.
REQ-029 SHALL ignore in_data whenever in_ready is low; no pixel is dropped or duplicated.
REQ-030 an output stall SHALL never corrupt the line buffer, since no input is accepted during EMIT.
REQ-031 SHALL emit IMG_WIDTH*IMG_HEIGHT elements per frame: (IMG_WIDTH/2)*(IMG_HEIGHT/2) windows.
REQ-032 SHALL size the col and row_pair counters by $clog2 of their range; the counters never wrap past their terminal values.
REQ-033 SHALL pass pixel values unchanged, with no arithmetic, so the downstream max pool applies signed compare semantics.

Reset
REQ-034 reset SHALL force, asynchronously: state=TOP, col=0, row_pair=0, e=0, out_data=0, out_valid=0, window_last=0, frame_done=0, and in_ready=enable.
REQ-035 line buffer contents SHALL need no reset, because every entry is written before it is read.
REQ-036 reset asserted mid-frame or mid-EMIT SHALL discard the partial window and the partial frame; the first pixel after reset is treated as row 0, col 0.

Verification
REQ-037 With IMG_WIDTH=4, IMG_HEIGHT=2, out_ready=1, input 1..8 -> output 1,2,5,6 (window_last on 6) then 3,4,7,8 (window_last on 8); frame_done pulses one cycle after 8 transfers.
REQ-038 In the same setup, hold out_ready=0 for 3 cycles at e=1 -> out_data stays 2 and in_ready stays 0 throughout; the sequence then resumes 5,6 with nothing lost.
REQ-039 With in_valid toggling every other cycle and enable=0 for 5 cycles mid-row -> output sequence is identical to REQ-037.
REQ-040 Defaults 64x64, random pixels including 16'h8000 and 16'h7FFF -> 4096 elements and 1024 window_last pulses; order matches the reference model; exactly one frame_done pulse.
REQ-041 Assert reset during BOT1 of row_pair 0, then send 1..8 -> output exactly as in REQ-037; all outputs are 0 while reset is high.
REQ-042 Send two back-to-back frames -> two frame_done pulses; the second frame's first window appears with no extra idle state.
